// File: rtl/div_unit_pkg.sv
// Purpose: shared opcodes, FSM state encoding and decode helper for the EX-stage divider.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package div_unit_pkg;

    // EX-stage ALU control codes produced by the decoder
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    // Divider FSM state encodings (2 bits)
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    // True for either divide flavour; everything else is ignored by the divider
    function automatic logic is_div_code(input logic [7:0] op);
        return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
    endfunction

endpackage

// File: rtl/div_unit.sv
// Purpose: multi-cycle restoring divider (signed/unsigned) producing {HI=remainder, LO=quotient}.
// Latency: WIDTH+1 cycles from accepted start to the one-cycle ready pulse; 1 cycle for divide-by-zero.
// Backpressure: asserts stall (combinational) from the accepting cycle until the result is ready; flush cancels.
//
// Ports:
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   alucontrol EX-stage ALU control code; only EXE_DIV_OP / EXE_DIVU_OP launch a divide
//   start      EX instruction valid
//   flush      EX annul; cancels any operation, higher priority than start
//   a, b       dividend / divisor
//   stall      hold IF..EX this cycle
//   ready      one-cycle result-valid pulse
//   result     {remainder, quotient}; holds its value between operations
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [7:0]           alucontrol,
    input  logic                 start,
    input  logic                 flush,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 stall,
    output logic                 ready,
    output logic [2*WIDTH-1:0]   result
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + ONE_W;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    div_state_t             r_state;
    logic [CW-1:0]          r_cnt;
    logic [2*WIDTH:0]       r_work;     // {partial remainder (WIDTH+1), dividend/quotient (WIDTH)}
    logic [WIDTH-1:0]       r_divisor;  // divisor magnitude
    logic                   r_q_neg;
    logic                   r_r_neg;
    logic                   r_ready;
    logic [2*WIDTH-1:0]     r_result;

    // ------------------------------------------------------------------
    // Launch decode
    // ------------------------------------------------------------------
    logic                   w_is_div;
    logic                   w_is_signed;
    logic                   w_launch;
    logic                   w_a_neg;
    logic                   w_b_neg;
    logic [WIDTH-1:0]       w_a_mag;
    logic [WIDTH-1:0]       w_b_mag;
    logic                   w_b_zero;

    assign w_is_div    = start & is_div_code(alucontrol);
    assign w_is_signed = (alucontrol == EXE_DIV_OP);
    assign w_launch    = w_is_div & ~flush;
    assign w_a_neg     = w_is_signed & a[WIDTH-1];
    assign w_b_neg     = w_is_signed & b[WIDTH-1];
    // 0x80000000 negates to itself, which is the correct magnitude when read unsigned
    assign w_a_mag     = w_a_neg ? negate(a) : a;
    assign w_b_mag     = w_b_neg ? negate(b) : b;
    assign w_b_zero    = (b == '0);

    // ------------------------------------------------------------------
    // One restoring step
    // ------------------------------------------------------------------
    logic [2*WIDTH:0]       w_shift;
    logic [WIDTH+1:0]       w_diff;
    logic                   w_fits;
    logic [2*WIDTH:0]       w_next_work;
    logic [WIDTH-1:0]       w_quo;
    logic [WIDTH-1:0]       w_rem;
    logic [WIDTH-1:0]       w_quo_fix;
    logic [WIDTH-1:0]       w_rem_fix;

    assign w_shift = {r_work[2*WIDTH-1:0], 1'b0};
    // The bit shifted out of the top joins the trial subtraction so no magnitude is lost;
    // an extra guard bit makes the borrow visible as the MSB.
    assign w_diff  = {r_work[2*WIDTH], w_shift[2*WIDTH:WIDTH]} - {2'b00, r_divisor};
    assign w_fits  = ~w_diff[WIDTH+1];

    assign w_next_work = w_fits ? {w_diff[WIDTH:0], w_shift[WIDTH-1:1], 1'b1} : w_shift;

    assign w_quo     = w_next_work[WIDTH-1:0];
    assign w_rem     = w_next_work[2*WIDTH-1:WIDTH];
    // Signed overflow (MIN / -1) falls out naturally: quotient wraps to MIN, remainder 0.
    assign w_quo_fix = r_q_neg ? negate(w_quo) : w_quo;
    assign w_rem_fix = r_r_neg ? negate(w_rem) : w_rem;

    // ------------------------------------------------------------------
    // FSM and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= DIV_IDLE;
            r_cnt     <= '0;
            r_work    <= '0;
            r_divisor <= '0;
            r_q_neg   <= 1'b0;
            r_r_neg   <= 1'b0;
            r_ready   <= 1'b0;
            r_result  <= '0;
        end else begin
            r_ready <= 1'b0;
            if (flush) begin
                // Annul wins over everything: drop the operation, leave result untouched
                r_state <= DIV_IDLE;
            end else begin
                case (r_state)
                    DIV_IDLE: begin
                        if (w_is_div) begin
                            r_divisor <= w_b_mag;
                            r_q_neg   <= w_a_neg ^ w_b_neg;
                            r_r_neg   <= w_a_neg;
                            r_work    <= {{(WIDTH+1){1'b0}}, w_a_mag};
                            r_cnt     <= '0;
                            if (w_b_zero) begin
                                // Divide-by-zero: raw dividend in HI, all-ones in LO, no iteration
                                r_result <= {a, {WIDTH{1'b1}}};
                                r_ready  <= 1'b1;
                                r_state  <= DIV_DONE;
                            end else begin
                                r_state  <= DIV_BUSY;
                            end
                        end
                    end
                    DIV_BUSY: begin
                        r_work <= w_next_work;
                        r_cnt  <= r_cnt + CNT_ONE;
                        if (r_cnt == CNT_LAST) begin
                            r_result <= {w_rem_fix, w_quo_fix};
                            r_ready  <= 1'b1;
                            r_state  <= DIV_DONE;
                        end
                    end
                    DIV_DONE: begin
                        // Never relaunch from the start that produced this result
                        r_state <= DIV_IDLE;
                    end
                    default: begin
                        r_state <= DIV_IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign stall  = ((r_state == DIV_IDLE) & w_launch) | (r_state == DIV_BUSY);
    assign ready  = r_ready;
    assign result = r_result;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;
    import div_unit_pkg::*;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           resetn;
    logic [7:0]     alucontrol;
    logic           start;
    logic           flush;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           stall;
    logic           ready;
    logic [2*W-1:0] result;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] sb_q[$];

    always #5 clk = ~clk;

    div_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .alucontrol (alucontrol),
        .start      (start),
        .flush      (flush),
        .a          (a),
        .b          (b),
        .stall      (stall),
        .ready      (ready),
        .result     (result)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference divide: truncating division on magnitudes with sign fix-up
    function automatic logic [63:0] model(input logic [7:0] op, input logic [31:0] av,
                                          input logic [31:0] bv);
        logic sgn, an, bn;
        logic [31:0] am, bm, q, r;
        if (bv == 32'd0) return {av, 32'hFFFF_FFFF};
        sgn = (op == EXE_DIV_OP);
        an  = sgn & av[31];
        bn  = sgn & bv[31];
        am  = an ? (32'd0 - av) : av;
        bm  = bn ? (32'd0 - bv) : bv;
        q   = am / bm;
        r   = am % bm;
        if (an ^ bn) q = 32'd0 - q;
        if (an)      r = 32'd0 - r;
        return {r, q};
    endfunction

    // Launch one divide, check stall every cycle, ready latency, and scoreboard result
    task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] av,
                          input logic [31:0] bv, input logic [63:0] exp, input int lat);
        bit seen;
        @(posedge clk); #1;
        start = 1'b1; alucontrol = op; a = av; b = bv;
        sb_q.push_back(exp);
        @(negedge clk);
        check({tag, "_stall_c0"}, 64'(stall), 64'd1);
        check({tag, "_ready_c0"}, 64'(ready), 64'd0);
        @(posedge clk); #1;
        start = 1'b0; alucontrol = 8'h00; a = $urandom; b = $urandom;
        seen = 1'b0;
        for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
            @(negedge clk);
            check({tag, "_stall"}, 64'(stall), 64'(cyc < lat));
            if (ready) begin
                seen = 1'b1;
                check({tag, "_lat"}, 64'(cyc), 64'(lat));
                if (sb_q.size() == 0) begin
                    check({tag, "_sb_empty"}, 64'd1, 64'd0);
                end else begin
                    check({tag, "_result"}, result, sb_q.pop_front());
                end
            end else begin
                @(posedge clk); #1;
            end
        end
        check({tag, "_ready_seen"}, 64'(seen), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_ready_pulse"}, 64'(ready), 64'd0);
        check({tag, "_stall_after"}, 64'(stall), 64'd0);
    endtask

    initial begin
        int pulses;
        int stalls;
        logic [7:0]  op;
        logic [31:0] av, bv;

        resetn = 1'b0; alucontrol = 8'h00; start = 1'b0; flush = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check("rst_stall",  64'(stall), 64'd0);
        check("rst_ready",  64'(ready), 64'd0);
        check("rst_result", result, 64'd0);

        // Directed results
        run_op("divu_100_7",  EXE_DIVU_OP, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
        run_op("div_m7_2",    EXE_DIV_OP,  32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
        run_op("div_7_m2",    EXE_DIV_OP,  32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33);
        run_op("divu_5_0",    EXE_DIVU_OP, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 1);
        run_op("div_ovf",     EXE_DIV_OP,  32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33);
        run_op("divu_ovf",    EXE_DIVU_OP, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'd0}, 33);

        // Flush mid-BUSY: no ready, stall drops next cycle, result keeps previous value
        @(posedge clk); #1;
        start = 1'b1; alucontrol = EXE_DIVU_OP; a = 32'd50; b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0; alucontrol = 8'h00;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("flush_stall_c10", 64'(stall), 64'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_stall_c11", 64'(stall), 64'd0);
        pulses = 0;
        stalls = 0;
        repeat (30) begin
            @(negedge clk);
            if (ready) pulses++;
            if (stall) stalls++;
        end
        check("flush_no_ready", 64'(pulses), 64'd0);
        check("flush_no_stall", 64'(stalls), 64'd0);
        check("flush_result_held", result, {32'h8000_0000, 32'd0});
        run_op("divu_9_3", EXE_DIVU_OP, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

        // Flush in IDLE beats start
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; alucontrol = EXE_DIV_OP; a = 32'd40; b = 32'd4;
        #1 check("idle_flush_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0; alucontrol = 8'h00;
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (ready || stall) pulses++;
        end
        check("idle_flush_quiet", 64'(pulses), 64'd0);

        // Asynchronous reset during BUSY
        @(posedge clk); #1;
        start = 1'b1; alucontrol = EXE_DIVU_OP; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; alucontrol = 8'h00;
        repeat (11) @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        check("arst_stall",  64'(stall), 64'd0);
        check("arst_ready",  64'(ready), 64'd0);
        check("arst_result", result, 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;

        // Non-div code with start never stalls
        start = 1'b1; alucontrol = 8'h20; a = 32'd9; b = 32'd3;
        #1 check("nondiv_stall_now", 64'(stall), 64'd0);
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (ready || stall) pulses++;
        end
        check("nondiv_quiet", 64'(pulses), 64'd0);
        @(posedge clk); #1;
        start = 1'b0; alucontrol = 8'h00;

        // Random operands against the reference model
        for (int i = 0; i < 8; i++) begin
            op = i[0] ? EXE_DIV_OP : EXE_DIVU_OP;
            av = $urandom;
            bv = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            if (i == 5) bv = 32'hFFFF_FFF5;
            if (i == 6) bv = 32'd0;
            run_op("rand", op, av, bv, model(op, av, bv), (bv == 32'd0) ? 1 : 33);
        end

        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
